// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined 16-bit CPU: widths, opcodes, bubble encoding
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OPC_B   = 4'hC;
  localparam logic [3:0] OPC_BR  = 4'hD;
  localparam logic [3:0] OPC_PCS = 4'hE;
  localparam logic [3:0] OPC_HLT = 4'hF;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_S  = 2'd0,
    WAIT_S   = 2'd1,
    HALTED_S = 2'd2
  } fetchState_e;

  function automatic logic isOpcode(input logic [15:0] instr, input logic [3:0] opc);
    return instr[15:12] == opc;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: bubble load clears it synchronously, wen loads a fetched word,
// neither holds the current contents.
module ifid_reg #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wen,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] nextInstr,
  input  logic [ADDR_W-1:0]  nextPcPlus2,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pcPlus2,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= '0;
      pcPlus2 <= '0;
      valid   <= 1'b0;
    end else if (bubble) begin
      instr   <= '0;
      pcPlus2 <= '0;
      valid   <= 1'b0;
    end else if (wen) begin
      instr   <= nextInstr;
      pcPlus2 <= nextPcPlus2;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests, tolerates multi-cycle
// memory, honours stall/flush and stops fetching on HLT.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          INSTR_W  = 16,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OPC = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus2,
  output logic               ifid_valid,
  output logic               fetch_halted
);

  fetchState_e       state;
  logic              redirectPend;
  logic [ADDR_W-1:0] redirectTgt;
  logic [ADDR_W-1:0] pcPlus2;
  logic              haltWord;
  logic              accept;
  logic              holdIfid;
  logic              ifidBubble;

  assign pcPlus2  = pc + ADDR_W'(2);
  assign haltWord = isOpcode(imem_data, HALT_OPC);

  // A word is taken only when it belongs to the current pc and nothing overrides it;
  // data arriving for a redirected-away fetch is never accepted.
  assign accept = imem_valid && !flush && !stall &&
                  ((state == FETCH_S) || (state == WAIT_S && !redirectPend));
  assign holdIfid   = stall && !flush && (state != HALTED_S);
  assign ifidBubble = !accept && !holdIfid;

  assign imem_addr    = pc;
  assign imem_req     = (state != HALTED_S);
  assign fetch_halted = (state == HALTED_S);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      state        <= FETCH_S;
      redirectPend <= 1'b0;
      redirectTgt  <= '0;
    end else begin
      case (state)
        FETCH_S: begin
          if (flush) begin
            pc <= branch_target;
          end else if (!imem_valid) begin
            state <= WAIT_S;
          end else if (!stall) begin
            if (haltWord) state <= HALTED_S;
            else          pc    <= pcPlus2;
          end
        end
        WAIT_S: begin
          // pc must stay stable while the memory is busy, so a redirect is parked
          // until the outstanding fetch returns.
          if (flush) begin
            if (imem_valid) begin
              pc           <= branch_target;
              redirectPend <= 1'b0;
              state        <= FETCH_S;
            end else begin
              redirectPend <= 1'b1;
              redirectTgt  <= branch_target;
            end
          end else if (imem_valid) begin
            state <= FETCH_S;
            if (redirectPend) begin
              pc           <= redirectTgt;
              redirectPend <= 1'b0;
            end else if (!stall) begin
              if (haltWord) state <= HALTED_S;
              else          pc    <= pcPlus2;
            end
          end
        end
        HALTED_S: begin
          if (flush) begin
            pc    <= branch_target;
            state <= FETCH_S;
          end
        end
        default: state <= FETCH_S;
      endcase
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (accept),
    .bubble     (ifidBubble),
    .nextInstr  (imem_data),
    .nextPcPlus2(pcPlus2),
    .instr      (ifid_instr),
    .pcPlus2    (ifid_pc_plus2),
    .valid      (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each cycle's expected pc / IF/ID / halt state is
// queued with the stimulus and popped after the clock edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [15:0] branch_target;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        fetch_halted;

  int vectors     = 0;
  int miscompares = 0;

  // {pc, valid, instr, pc_plus2, halted}
  logic [49:0] exp_q[$];

  localparam logic [15:0] HALT_ADDR = 16'h0008;

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (a == HALT_ADDR) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  assign imem_data = word_at(imem_addr);

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .branch_target(branch_target),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2),
    .ifid_valid   (ifid_valid),
    .fetch_halted (fetch_halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic [49:0] e);
    chk("pc",        pc,                       e[49:34]);
    chk("imem_addr", imem_addr,                e[49:34]);
    chk("ifid_valid", {15'd0, ifid_valid},     {15'd0, e[33]});
    chk("ifid_instr", ifid_instr,              e[32:17]);
    chk("ifid_pc_plus2", ifid_pc_plus2,        e[16:1]);
    chk("fetch_halted", {15'd0, fetch_halted}, {15'd0, e[0]});
    chk("imem_req", {15'd0, imem_req},         {15'd0, ~e[0]});
  endtask

  // One clock: drive inputs, queue what must hold after the edge, then compare.
  task automatic step(input logic st, input logic fl, input logic [15:0] tgt, input logic iv,
                      input logic [15:0] e_pc, input logic e_v, input logic [15:0] e_instr,
                      input logic [15:0] e_pp2, input logic e_halt);
    logic [49:0] e;
    exp_q.push_back({e_pc, e_v, e_instr, e_pp2, e_halt});
    stall = st;
    flush = fl;
    branch_target = tgt;
    imem_valid = iv;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      check_outputs(e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    branch_target = 16'h0000;
    imem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0});
    check_outputs(exp_q.pop_front());
    rst_n = 1'b1;

    // sequential hits
    step(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h1000, 16'h0002, 0);
    step(0, 0, 16'h0000, 1, 16'h0004, 1, 16'h1002, 16'h0004, 0);
    // stall holds pc and IF/ID, then resumes at 4
    step(1, 0, 16'h0000, 1, 16'h0004, 1, 16'h1002, 16'h0004, 0);
    step(1, 0, 16'h0000, 1, 16'h0004, 1, 16'h1002, 16'h0004, 0);
    step(0, 0, 16'h0000, 1, 16'h0006, 1, 16'h1004, 16'h0006, 0);
    // flush beats stall
    step(1, 1, 16'h0040, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 16'h0000, 1, 16'h0042, 1, 16'h1040, 16'h0042, 0);
    step(0, 1, 16'h0006, 1, 16'h0006, 0, 16'h0000, 16'h0000, 0);
    // miss at 6 with redirect parked in the 2nd wait cycle
    step(0, 0, 16'h0000, 0, 16'h0006, 0, 16'h0000, 16'h0000, 0);
    step(0, 1, 16'h0100, 0, 16'h0006, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 16'h0000, 0, 16'h0006, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 16'h0000, 1, 16'h0102, 1, 16'h1100, 16'h0102, 0);
    // HLT at 8, stall ignored while halted, flush restarts fetch
    step(0, 1, 16'h0008, 1, 16'h0008, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 16'h0000, 1, 16'h0008, 1, 16'hF000, 16'h000A, 1);
    step(1, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000, 16'h0000, 1);
    step(0, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000, 16'h0000, 1);
    step(0, 1, 16'h0020, 1, 16'h0020, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 16'h0000, 1, 16'h0022, 1, 16'h1020, 16'h0022, 0);
    // stall across a miss keeps IF/ID, the returning word is dropped and refetched
    step(1, 0, 16'h0000, 0, 16'h0022, 1, 16'h1020, 16'h0022, 0);
    step(1, 0, 16'h0000, 1, 16'h0022, 1, 16'h1020, 16'h0022, 0);
    step(0, 0, 16'h0000, 1, 16'h0024, 1, 16'h1022, 16'h0024, 0);
    // flush during a miss cycle in FETCH
    step(0, 1, 16'h0030, 0, 16'h0030, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 16'h0000, 1, 16'h0032, 1, 16'h1030, 16'h0032, 0);
    // pc wrap at 0xFFFE
    step(0, 1, 16'hFFFE, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 16'h0000, 1, 16'h0000, 1, 16'h1FFE, 16'h0000, 0);
    // flush together with imem_valid in WAIT: target wins
    step(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    step(0, 1, 16'h0300, 1, 16'h0300, 0, 16'h0000, 16'h0000, 0);
    // reset mid-WAIT with a parked redirect
    step(0, 0, 16'h0000, 0, 16'h0300, 0, 16'h0000, 16'h0000, 0);
    step(0, 1, 16'h0500, 0, 16'h0300, 0, 16'h0000, 16'h0000, 0);
    #1;
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.push_back({16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0});
    check_outputs(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h1000, 16'h0002, 0);
    step(0, 0, 16'h0000, 1, 16'h0004, 1, 16'h1002, 16'h0004, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
